hififo_read_scheduler: RTL and testbench

- Sits between the per-channel page request unit and the PCIe read-request TLP generator on the host-to-FPGA path.
- Accepts one (address, count) page entry per channel into a holding slot.
- Splits each entry into read requests that never exceed MRRS_QW qwords or cross an MRRS_QW boundary.
- Arbitrates round-robin among channels and allocates a completion tag from a 32-entry pool for every request issued.

---
 rtl/hififo_read_scheduler_if.sv | 24 ++
 rtl/hififo_read_scheduler.sv | 109 ++++++++++
 tb/tb_hififo_read_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hififo_read_scheduler_if.sv
// hififo_read_scheduler_if: page-entry intake, read-request issue and tag-release signals
interface hififo_read_scheduler_if;
   logic [7:0]  r_valid;
   logic [60:0] r_addr;
   logic [18:0] r_count;
   logic [7:0]  r_ready;
   logic        rq_valid;
   logic        rq_ready;
   logic [60:0] rq_addr;
   logic [9:0]  rq_len;
   logic [4:0]  rq_tag;
   logic [2:0]  rq_chan;
   logic        tag_release;
   logic [4:0]  tag_id;
   logic [7:0]  chan_done;
   modport master (
      input  r_valid, r_addr, r_count, rq_ready, tag_release, tag_id,
      output r_ready, rq_valid, rq_addr, rq_len, rq_tag, rq_chan, chan_done
   );
   modport slave (
      output r_valid, r_addr, r_count, rq_ready, tag_release, tag_id,
      input  r_ready, rq_valid, rq_addr, rq_len, rq_tag, rq_chan, chan_done
   );
endinterface

// File: rtl/hififo_read_scheduler.sv
// hififo_read_scheduler: splits per-channel page entries into MRRS-bounded read requests,
// round-robin across channels, with a completion-tag pool.
module hififo_read_scheduler #(
   parameter logic [7:0] ENABLE  = 8'b00010001,
   parameter int         MRRS_QW = 64,
   parameter int         NTAGS   = 32
) (
   input logic                    clock,
   input logic                    reset,
   hififo_read_scheduler_if.master bus
);
   localparam logic [60:0] OFS_MASK = 61'(MRRS_QW - 1);
   localparam logic [31:0] TAG_MASK = 32'((64'd1 << NTAGS) - 64'd1);
   typedef enum logic [1:0] {IDLE, ARB, ISSUE} state_t;
   state_t      r_state;
   logic [7:0]  r_slot_v;
   logic [60:0] r_slot_addr [8];
   logic [18:0] r_slot_rem [8];
   logic [2:0]  r_rr;
   logic [31:0] r_tag_busy;
   logic [7:0]  r_chan_done;
   logic        r_rq_valid;
   logic [60:0] r_rq_addr;
   logic [9:0]  r_rq_len;
   logic [4:0]  r_rq_tag;
   logic [2:0]  r_rq_chan;
   logic [2:0]  w_grant;
   logic        w_found;
   logic [4:0]  w_tag;
   logic [31:0] w_tag_free;
   logic [19:0] w_room;
   logic [9:0]  w_len;
   logic        w_hs;
   logic [7:0]  w_clear;
   logic [7:0]  w_accept;
   always_comb begin
      w_tag_free = ~r_tag_busy & TAG_MASK;
      w_found = 1'b0;
      w_grant = r_rr;
      for (int k = 0; k < 8; k++)
         if (!w_found && r_slot_v[3'(r_rr + 3'(k))]) begin
            w_found = 1'b1;
            w_grant = 3'(r_rr + 3'(k));
         end
      w_tag = '0;
      for (int i = NTAGS - 1; i >= 0; i--)
         if (w_tag_free[i]) w_tag = 5'(i);
      w_room = 20'(MRRS_QW) - 20'(r_slot_addr[w_grant] & OFS_MASK);
      w_len = ({1'b0, r_slot_rem[w_grant]} < w_room) ? r_slot_rem[w_grant][9:0] : w_room[9:0];
      w_hs = r_state == ISSUE && bus.rq_ready;
      w_clear = (w_hs && r_slot_rem[r_rq_chan] == 19'(r_rq_len)) ? 8'd1 << r_rq_chan : 8'd0;
      // a slot being retired this cycle may be reloaded in the same cycle
      w_accept = bus.r_valid & ENABLE & (~r_slot_v | w_clear);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_state     <= IDLE;
         r_slot_v    <= '0;
         r_slot_addr <= '{default: '0};
         r_slot_rem  <= '{default: '0};
         r_rr        <= '0;
         r_tag_busy  <= '0;
         r_chan_done <= '0;
         r_rq_valid  <= 1'b0;
         r_rq_addr   <= '0;
         r_rq_len    <= '0;
         r_rq_tag    <= '0;
         r_rq_chan   <= '0;
      end else begin
         r_chan_done <= w_clear | (bus.r_count == '0 ? w_accept : 8'h0);
         r_slot_v    <= (r_slot_v & ~w_clear) | (bus.r_count != '0 ? w_accept : 8'h0);
         if (bus.tag_release) r_tag_busy[bus.tag_id] <= 1'b0;
         if (w_hs) begin
            r_slot_addr[r_rq_chan] <= r_slot_addr[r_rq_chan] + 61'(r_rq_len);
            r_slot_rem[r_rq_chan]  <= r_slot_rem[r_rq_chan] - 19'(r_rq_len);
            r_rr                   <= r_rq_chan + 3'd1;
         end
         for (int i = 0; i < 8; i++)
            if (w_accept[i]) begin
               r_slot_addr[i] <= bus.r_addr;
               r_slot_rem[i]  <= bus.r_count;
            end
         case (r_state)
            IDLE: if (|r_slot_v && |w_tag_free) r_state <= ARB;
            ARB: begin
               // allocation follows the release above so it wins on a shared tag
               r_tag_busy[w_tag] <= 1'b1;
               r_rq_valid        <= 1'b1;
               r_rq_addr         <= r_slot_addr[w_grant];
               r_rq_len          <= w_len;
               r_rq_tag          <= w_tag;
               r_rq_chan         <= w_grant;
               r_state           <= ISSUE;
            end
            ISSUE: if (bus.rq_ready) begin
               r_rq_valid <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   assign bus.r_ready   = ENABLE & ~r_slot_v;
   assign bus.rq_valid  = r_rq_valid;
   assign bus.rq_addr   = r_rq_addr;
   assign bus.rq_len    = r_rq_len;
   assign bus.rq_tag    = r_rq_tag;
   assign bus.rq_chan   = r_rq_chan;
   assign bus.chan_done = r_chan_done;
endmodule

// File: tb/tb_hififo_read_scheduler.sv
// tb_hififo_read_scheduler: directed scenarios plus randomized traffic checked against
// a slot/tag-pool reference model.
module tb_hififo_read_scheduler;
   localparam logic [7:0] EN = 8'h11;
   localparam int MRRS = 64;
   localparam int NT = 32;
   typedef struct {
      logic [2:0]  chan;
      logic [60:0] addr;
      logic [9:0]  len;
      logic [4:0]  tag;
      int          cyc;
   } req_t;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   hififo_read_scheduler_if bus();
   hififo_read_scheduler #(.ENABLE(EN), .MRRS_QW(MRRS), .NTAGS(NT)) dut (
      .clock(clock), .reset(reset), .bus(bus));
   int checks = 0, failures = 0, cyc = 0, load_cyc;
   req_t log_q[$];
   req_t cur;
   bit issuing;
   logic [7:0] m_v, s_v, exp_done;
   logic [60:0] m_addr [8], s_addr [8];
   int m_rem [8], s_rem [8];
   bit [31:0] m_busy, s_busy;
   int m_rr, s_rr;
   int done_seen [8];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model_init();
      m_v = '0; exp_done = '0; m_busy = '0; m_rr = 0; issuing = 0;
      for (int i = 0; i < 8; i++) begin m_addr[i] = '0; m_rem[i] = 0; done_seen[i] = 0; end
      log_q.delete();
   endtask
   task automatic model_edge();
      cyc++;
      s_v = m_v; s_addr = m_addr; s_rem = m_rem; s_busy = m_busy; s_rr = m_rr;
      exp_done = '0;
      if (issuing && bus.rq_ready) begin
         m_addr[cur.chan] = m_addr[cur.chan] + 61'(cur.len);
         m_rem[cur.chan] -= int'(cur.len);
         m_rr = (int'(cur.chan) + 1) % 8;
         if (m_rem[cur.chan] == 0) begin m_v[cur.chan] = 1'b0; exp_done[cur.chan] = 1'b1; end
         issuing = 0;
      end
      if (bus.tag_release) m_busy[bus.tag_id] = 1'b0;
      for (int i = 0; i < 8; i++)
         if (bus.r_valid[i] && EN[i] && !m_v[i]) begin
            if (bus.r_count == 0) exp_done[i] = 1'b1;
            else begin m_v[i] = 1'b1; m_addr[i] = bus.r_addr; m_rem[i] = int'(bus.r_count); end
         end
   endtask
   task automatic observe();
      int c, t, room;
      req_t e;
      chk("r_ready", bus.r_ready, EN & ~m_v);
      chk("chan_done", bus.chan_done, exp_done);
      for (int i = 0; i < 8; i++) if (bus.chan_done[i]) done_seen[i]++;
      if (bus.rq_valid && !issuing) begin
         c = -1; t = -1;
         for (int k = 0; k < 8; k++) if (c < 0 && s_v[(s_rr + k) % 8]) c = (s_rr + k) % 8;
         for (int i = NT - 1; i >= 0; i--) if (!s_busy[i]) t = i;
         if (c < 0 || t < 0) chk("rq_allowed", bus.rq_valid, 0);
         else begin
            room = MRRS - int'(s_addr[c] % MRRS);
            e.chan = 3'(c); e.addr = s_addr[c]; e.tag = 5'(t); e.cyc = cyc;
            e.len = 10'(s_rem[c] < room ? s_rem[c] : room);
            cur = e; issuing = 1; m_busy[t] = 1'b1; log_q.push_back(e);
         end
      end
      if (issuing) begin
         chk("rq_valid", bus.rq_valid, 1);
         chk("rq_chan", bus.rq_chan, cur.chan);
         chk("rq_addr", bus.rq_addr, cur.addr);
         chk("rq_len", bus.rq_len, cur.len);
         chk("rq_tag", bus.rq_tag, cur.tag);
      end
   endtask
   task automatic cycle();
      @(posedge clock); model_edge();
      @(negedge clock); observe();
   endtask
   task automatic do_reset();
      reset = 1'b0;
      bus.r_valid = '0; bus.r_addr = '0; bus.r_count = '0;
      bus.rq_ready = 1'b1; bus.tag_release = 1'b0; bus.tag_id = '0;
      model_init();
      repeat (2) @(negedge clock);
      chk("rst_rq_valid", bus.rq_valid, 0);
      chk("rst_r_ready", bus.r_ready, EN);
      chk("rst_chan_done", bus.chan_done, 0);
      reset = 1'b1;
   endtask
   task automatic load(input logic [7:0] m, input logic [60:0] a, input int n);
      bus.r_valid = m; bus.r_addr = a; bus.r_count = 19'(n);
      cycle(); load_cyc = cyc;
      bus.r_valid = '0;
   endtask
   task automatic run_until(input int n, input int bound);
      for (int k = 0; k < bound && log_q.size() < n; k++) cycle();
   endtask
   initial begin
      int lens [4] = '{64, 64, 64, 8};
      int chans [4] = '{0, 4, 0, 4};
      // single channel, aligned 200-qword page
      do_reset();
      load(8'h01, 61'h1000, 200);
      run_until(4, 100);
      repeat (4) cycle();
      chk("t1_count", log_q.size(), 4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         chk("t1_addr", log_q[i].addr, 61'h1000 + 61'(64 * i));
         chk("t1_len", log_q[i].len, lens[i]);
         chk("t1_tag", log_q[i].tag, i);
         chk("t1_chan", log_q[i].chan, 0);
      end
      if (log_q.size() >= 2) begin
         chk("t1_latency", log_q[0].cyc - load_cyc, 2);
         chk("t1_rate", log_q[1].cyc - log_q[0].cyc, 3);
      end
      chk("t1_done", done_seen[0], 1);
      // unaligned entry straddling a boundary
      do_reset();
      load(8'h01, 61'h103C, 10);
      run_until(2, 50);
      chk("t2_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("t2_len0", log_q[0].len, 4);
         chk("t2_addr0", log_q[0].addr, 61'h103C);
         chk("t2_len1", log_q[1].len, 6);
         chk("t2_addr1", log_q[1].addr, 61'h1040);
      end
      // two channels, backpressure on the first request
      do_reset();
      bus.rq_ready = 1'b0;
      load(8'h11, 61'h2000, 128);
      run_until(1, 20);
      repeat (5) cycle();
      chk("t3_held", log_q.size(), 1);
      bus.rq_ready = 1'b1;
      run_until(4, 60);
      chk("t3_count", log_q.size(), 4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) begin
         chk("t3_chan", log_q[i].chan, chans[i]);
         chk("t3_addr", log_q[i].addr, 61'h2000 + 61'(64 * (i / 2)));
      end
      // tag pool exhaustion then single release
      do_reset();
      load(8'h01, 61'h0, 64 * 40);
      repeat (150) cycle();
      chk("t4_count", log_q.size(), 32);
      chk("t4_stall", bus.rq_valid, 0);
      bus.tag_release = 1'b1; bus.tag_id = 5'd7;
      cycle();
      bus.tag_release = 1'b0;
      run_until(33, 20);
      chk("t4_count2", log_q.size(), 33);
      if (log_q.size() == 33) chk("t4_tag", log_q[32].tag, 7);
      // zero-length entry
      do_reset();
      load(8'h10, 61'h3000, 0);
      chk("t5_done", bus.chan_done, 8'h10);
      repeat (10) cycle();
      chk("t5_noreq", log_q.size(), 0);
      chk("t5_ready", bus.r_ready, 8'h11);
      chk("t5_done_cnt", done_seen[4], 1);
      // asynchronous reset while a request is pending
      do_reset();
      bus.rq_ready = 1'b0;
      load(8'h01, 61'h4000, 100);
      run_until(1, 20);
      chk("t6_pending", bus.rq_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_rq_valid", bus.rq_valid, 0);
      chk("t6_r_ready", bus.r_ready, 8'h11);
      chk("t6_chan_done", bus.chan_done, 0);
      model_init();
      @(negedge clock);
      reset = 1'b1; bus.rq_ready = 1'b1;
      load(8'h10, 61'h500, 3);
      run_until(1, 20);
      chk("t6_count", log_q.size(), 1);
      if (log_q.size() == 1) begin
         chk("t6_tag", log_q[0].tag, 0);
         chk("t6_chan", log_q[0].chan, 4);
         chk("t6_len", log_q[0].len, 3);
      end
      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bus.r_valid = ($urandom_range(0, 5) == 0) ? 8'($urandom()) : 8'h0;
         bus.r_addr = ($urandom_range(0, 3) == 0) ? 61'h1FFF_FFFF_FFFF_FFC0 + 61'($urandom_range(0, 63))
                                                  : 61'({$urandom(), $urandom()});
         bus.r_count = ($urandom_range(0, 5) == 0) ? 19'd0 : 19'($urandom_range(1, 300));
         bus.rq_ready = 1'($urandom_range(0, 1));
         bus.tag_release = ($urandom_range(0, 3) == 0);
         bus.tag_id = 5'($urandom_range(0, 31));
         cycle();
      end
      bus.r_valid = '0; bus.rq_ready = 1'b1;
      for (int n = 0; n < 5000 && (m_v != 0 || issuing); n++) begin
         bus.tag_release = 1'b1; bus.tag_id = '0;
         for (int i = NT - 1; i >= 0; i--) if (m_busy[i]) bus.tag_id = 5'(i);
         cycle();
      end
      bus.tag_release = 1'b0;
      repeat (3) cycle();
      chk("drain_r_ready", bus.r_ready, EN);
      chk("drain_rq_valid", bus.rq_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
